// File: rtl/aes_encipher_block_pkg.sv
// Shared AES constants, FSM encodings and round-function helpers for the encipher datapath.
// The state is held as four column words {w0,w1,w2,w3}, with byte 0 in the MSB.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      SBOX = 2'd2,
      MAIN = 2'd3
   } aes_state_t;

   localparam logic [3:0] AES128_ROUNDS = 4'd10;
   localparam logic [3:0] AES256_ROUNDS = 4'd14;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
              xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] s);
      return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
   endfunction

   // Row r of output column c comes from input column (c + r) mod 4.
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      w0 = s[127:96];
      w1 = s[95:64];
      w2 = s[63:32];
      w3 = s[31:0];
      return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
              w1[31:24], w2[23:16], w3[15:8], w0[7:0],
              w2[31:24], w3[23:16], w0[15:8], w1[7:0],
              w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/aes_encipher_block_sbox.sv
// Forward AES S-box on a 32-bit word: four parallel, purely combinational byte lookups.
module aes_sbox (
   input  logic [31:0] sword,
   output logic [31:0] new_sword
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign new_sword = {SBOX[sword[31:24]], SBOX[sword[23:16]], SBOX[sword[15:8]], SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher round engine, 5 cycles per round; ready rises 51 (128) or 71 (256) edges after next.
// No backpressure: next is ignored while busy. AES_ENC_INT_MIXCOL_EN selects internal MixColumns over b_mix/a_mix.
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready,
   output logic [127:0] b_mix,
   input  logic [127:0] a_mix
);

   aes_state_t   state, state_nxt;
   logic [3:0]   round_nxt, nr;
   logic [1:0]   sword_ctr, sword_ctr_nxt;
   logic         keylen_reg, keylen_nxt, ready_nxt;
   logic [127:0] block_nxt, sr_block, mix_block;
   logic [31:0]  sbox_in, sbox_out;

   assign sr_block = shiftrows(new_block);

`ifdef AES_ENC_INT_MIXCOL_EN
   assign b_mix     = '0;
   assign mix_block = mixcolumns(sr_block);
`else
   assign b_mix     = sr_block;
   assign mix_block = a_mix;
`endif

   assign nr = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;

   always_comb begin
      sbox_in = new_block[127:96];
      case (sword_ctr)
         2'd0: sbox_in = new_block[127:96];
         2'd1: sbox_in = new_block[95:64];
         2'd2: sbox_in = new_block[63:32];
         2'd3: sbox_in = new_block[31:0];
      endcase
   end

   aes_sbox u_sbox (
      .sword     (sbox_in),
      .new_sword (sbox_out)
   );

   always_comb begin
      state_nxt     = state;
      round_nxt     = round;
      sword_ctr_nxt = sword_ctr;
      keylen_nxt    = keylen_reg;
      ready_nxt     = ready;
      block_nxt     = new_block;
      case (state)
         IDLE: begin
            if (next) begin
               round_nxt  = 4'd0;
               keylen_nxt = keylen;
               ready_nxt  = 1'b0;
               state_nxt  = INIT;
            end
         end
         INIT: begin
            block_nxt     = addroundkey(block, round_key);
            round_nxt     = 4'd1;
            sword_ctr_nxt = 2'd0;
            state_nxt     = SBOX;
         end
         SBOX: begin
            case (sword_ctr)
               2'd0: block_nxt[127:96] = sbox_out;
               2'd1: block_nxt[95:64]  = sbox_out;
               2'd2: block_nxt[63:32]  = sbox_out;
               2'd3: block_nxt[31:0]   = sbox_out;
            endcase
            sword_ctr_nxt = sword_ctr + 2'd1;
            if (sword_ctr == 2'd3) begin
               state_nxt = MAIN;
            end
         end
         MAIN: begin
            // Final round skips MixColumns and leaves round parked at Nr.
            if (round == nr) begin
               block_nxt = addroundkey(sr_block, round_key);
               ready_nxt = 1'b1;
               state_nxt = IDLE;
            end else begin
               block_nxt = addroundkey(mix_block, round_key);
               round_nxt = round + 4'd1;
               state_nxt = SBOX;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         new_block  <= '0;
         round      <= 4'd0;
         sword_ctr  <= 2'd0;
         keylen_reg <= 1'b0;
         ready      <= 1'b1;
      end else begin
         state      <= state_nxt;
         new_block  <= block_nxt;
         round      <= round_nxt;
         sword_ctr  <= sword_ctr_nxt;
         keylen_reg <= keylen_nxt;
         ready      <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed bench for aes_encipher_block: key schedule and MixColumns are modelled here from GF(2^8) arithmetic.
module tb_aes_encipher_block;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;
   logic [127:0] b_mix;
   logic [127:0] a_mix;

   int total = 0;
   int bad   = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] rk [16];
   logic         bmix_nonzero = 1'b0;

   aes_encipher_block dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .block     (block),
      .new_block (new_block),
      .ready     (ready),
      .b_mix     (b_mix),
      .a_mix     (a_mix)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
      return s[127 - 8*k -: 8];
   endfunction

   function automatic logic [127:0] m_shiftrows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = byte_of(s, 4*((c + r) % 4) + r);
      return o;
   endfunction

   function automatic logic [127:0] m_mixcolumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = byte_of(s, 4*c);
         a1 = byte_of(s, 4*c + 1);
         a2 = byte_of(s, 4*c + 2);
         a3 = byte_of(s, 4*c + 3);
         o[127 - 32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
      end
      return o;
   endfunction

   assign round_key = rk[round];
`ifdef AES_ENC_INT_MIXCOL_EN
   assign a_mix = '1;
   always @(negedge clk) if (b_mix !== '0) bmix_nonzero = 1'b1;
`else
   assign a_mix = m_mixcolumns(b_mix);
`endif

   // S-box from the multiplicative inverse (x^254) followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv, x;
      for (int i = 0; i < 256; i++) begin
         x   = 8'(i);
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, x);
         sbox_m[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] m_subword(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   task automatic expand(input bit kl, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      int nk, nr;
      nk   = kl ? 8 : 4;
      nr   = kl ? 14 : 10;
      rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = m_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = m_subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Called at a negedge: drives next for the following sampling edge.
   task automatic start_op(input bit kl, input logic [255:0] key, input logic [127:0] pt);
      expand(kl, key);
      keylen = kl;
      block  = pt;
      next   = 1'b1;
   endtask

   task automatic wait_ready(output int edges, input int pa, input int pb, input bit hold);
      edges = 0;
      while (ready !== 1'b1 && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (!hold) begin
            if (edges == pa || edges == pb) begin
               next   = 1'b1;
               keylen = ~keylen;
            end else begin
               next = 1'b0;
            end
         end
      end
   endtask

   task automatic check_result(input string tag, input bit kl, input logic [127:0] ct, input int e);
      chk({tag, "_latency"}, 128'(e), kl ? 128'd71 : 128'd51);
      chk({tag, "_ct"}, new_block, ct);
      chk({tag, "_round"}, 128'(round), kl ? 128'd14 : 128'd10);
`ifdef AES_ENC_INT_MIXCOL_EN
      chk({tag, "_bmix"}, b_mix, 128'h0);
`else
      chk({tag, "_bmix"}, b_mix, m_shiftrows(ct));
`endif
   endtask

   task automatic run_vec(input string tag, input bit kl, input logic [255:0] key,
                          input logic [127:0] pt, input logic [127:0] ct, input int pa, input int pb);
      int e;
      @(negedge clk);
      start_op(kl, key, pt);
      @(posedge clk);
      @(negedge clk);
      next = 1'b0;
      chk({tag, "_busy"}, 128'(ready), 128'd0);
      wait_ready(e, pa, pb, 1'b0);
      check_result(tag, kl, ct, e);
   endtask

   typedef struct {
      bit           kl;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z128 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] CT_Z256 = 128'hdc95c078a2408989ad48a21492842087;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      vec_t b2b [3];
      int   e, cnt;

      vecs[0] = '{1'b0, KEY_C1, PT_C, CT_C1};
      vecs[1] = '{1'b1, KEY_C3, PT_C, CT_C3};
      vecs[2] = '{1'b0, KEY_B, PT_B, CT_B};
      vecs[3] = '{1'b0, 256'h0, 128'h0, CT_Z128};
      vecs[4] = '{1'b1, 256'h0, 128'h0, CT_Z256};
      b2b[0]  = vecs[0];
      b2b[1]  = vecs[3];
      b2b[2]  = vecs[2];

      build_sbox();
      for (int r = 0; r < 16; r++) rk[r] = '0;
      reset_n = 1'b0;
      next    = 1'b0;
      keylen  = 1'b0;
      block   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("reset_ready", 128'(ready), 128'd1);
      chk("reset_block", new_block, 128'h0);
      chk("reset_round", 128'(round), 128'd0);

      for (int i = 0; i < 5; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].kl, vecs[i].key, vecs[i].pt, vecs[i].ct, 0, 0);

      // Stray next pulses and keylen flips during a run must not disturb it.
      run_vec("pulse", 1'b0, KEY_C1, PT_C, CT_C1, 5, 30);
      next = 1'b0;
      repeat (3) @(negedge clk);
      chk("pulse_idle_ready", 128'(ready), 128'd1);
      chk("pulse_idle_hold", new_block, CT_C1);

      // Reset at round 6 aborts, then a fresh run must match.
      @(negedge clk);
      start_op(1'b0, KEY_C1, PT_C);
      @(posedge clk);
      @(negedge clk);
      next = 1'b0;
      cnt  = 0;
      while (round !== 4'd6 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("abort_reach_r6", 128'(round), 128'd6);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort_ready", 128'(ready), 128'd1);
      chk("abort_block", new_block, 128'h0);
      chk("abort_round", 128'(round), 128'd0);
      run_vec("after_abort", 1'b0, KEY_C1, PT_C, CT_C1, 0, 0);

      // next held high: each block must start the edge after ready rises.
      @(negedge clk);
      start_op(b2b[0].kl, b2b[0].key, b2b[0].pt);
      @(posedge clk);
      @(negedge clk);
      chk("b2b0_busy", 128'(ready), 128'd0);
      wait_ready(e, 0, 0, 1'b1);
      check_result("b2b0", b2b[0].kl, b2b[0].ct, e);
      for (int j = 1; j < 3; j++) begin
         start_op(b2b[j].kl, b2b[j].key, b2b[j].pt);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b2b%0d_restart", j), 128'(ready), 128'd0);
         wait_ready(e, 0, 0, 1'b1);
         check_result($sformatf("b2b%0d", j), b2b[j].kl, b2b[j].ct, e);
      end
      next = 1'b0;

`ifdef AES_ENC_INT_MIXCOL_EN
      chk("bmix_always_zero", 128'(bmix_nonzero), 128'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_encipher_block.md
AES_ENCIPHER_BLOCK -- requirements
Module: aes_encipher_block

Interface
REQ-001 Parameters: none; all constants SHALL come from the shared package.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 next  in  1  start pulse; sampled only in IDLE.
REQ-005 keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled with next.
REQ-006 round  out  4  current round index; the key schedule SHALL use it to select round_key.
REQ-007 round_key  in  128  round key for round; consumed in the same cycle.
REQ-008 block  in  128  plaintext; consumed in the INIT cycle.
REQ-009 new_block  out  128  state register {w0,w1,w2,w3}; holds ciphertext once ready rises.
REQ-010 ready  out  1  high when idle and the result is valid.
REQ-011 b_mix  out  128  combinational ShiftRows(new_block), sent to the external MixColumns.
REQ-012 a_mix  in  128  combinational MixColumns(b_mix), returned in the same cycle.

Function
REQ-013 FSM states SHALL be IDLE, INIT, SBOX and MAIN, encoded in 2 bits.
REQ-014 IDLE with next=1: round<=0, keylen_reg<=keylen, ready<=0, go to INIT; with next=0, hold all state.
REQ-015 INIT: state<=block^round_key (round 0), round<=1, sword_ctr<=0, go to SBOX.
REQ-016 SBOX: one 32-bit word per cycle, w[sword_ctr]<=SubWord(w[sword_ctr]); sword_ctr wraps 3->0; after word 3, go to MAIN.
REQ-017 MAIN with round<Nr: state<=a_mix^round_key, round<=round+1, go to SBOX.
REQ-018 MAIN with round==Nr: state<=b_mix^round_key (final round, no MixColumns), ready<=1, go to IDLE; round SHALL hold Nr.
REQ-019 Nr SHALL come from keylen_reg; a keylen change mid-operation SHALL have no effect.
REQ-020 Latency: ready SHALL rise 51 clock edges after the edge that samples next for AES-128, and 71 edges after it for AES-256.
REQ-021 next while busy SHALL be ignored; next held high SHALL start a new operation on the cycle after ready rises.
REQ-022 Round counter arithmetic SHALL be 4-bit unsigned; the counter SHALL never exceed 14.
REQ-023 new_block SHALL change only in INIT, SBOX and MAIN cycles; between operations it SHALL hold the last ciphertext.

Reset
REQ-024 reset_n=0 at a clock edge SHALL give: state IDLE, new_block=0, round=0, sword_ctr=0, keylen_reg=0, ready=1.
REQ-025 Reset asserted mid-operation SHALL abort the operation; the next start SHALL behave as from power-up.

Configuration
REQ-026 Macro AES_ENC_INT_MIXCOL_EN:
- defined: MixColumns SHALL be computed internally; a_mix SHALL be ignored; b_mix SHALL be driven 0.
- undefined: MixColumns SHALL use the external b_mix/a_mix path per REQ-011/012.
- Cycle timing SHALL be identical in both builds.

Structure
REQ-027 Package aes_pkg SHALL hold: FSM state encodings, AES128_ROUNDS=10, AES256_ROUNDS=14, and the ShiftRows, AddRoundKey, GF(2^8) xtime and MixColumns functions.
REQ-028 One sub-module, aes_sbox (32-bit forward S-box, 4 parallel byte lookups), SHALL be instantiated once.

Verification
REQ-029 Bench scenarios:
- FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, ready rises 51 edges after next.
- FIPS-197 C.3 (keylen=1, key 000102..1f), same pt -> 8ea2b7ca516745bfeafc49904b496089 after 71 edges; round reaches 14.
- next pulsed at cycles 5 and 30 of an AES-128 run, and keylen toggled mid-run -> a single C.1 result, latency unchanged.
- reset_n low for one cycle at round 6 -> ready=1, new_block=0, round=0; a fresh C.1 run then passes.
- next held high for 3 back-to-back blocks -> three correct ciphertexts; each operation starts one cycle after ready rises.
- Build with AES_ENC_INT_MIXCOL_EN and a_mix tied to all-ones -> C.1 and C.3 still pass; b_mix stays 0.
